// File: rtl/div_ctrl.sv
// Sequencing controller and radix-2 restoring divider for MIPS DIV/DIVU in EX.
// Produces {remainder, quotient} for the HI/LO write and stalls the pipe while busy.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  input  logic               flush,
  output logic               stall_div,
  output logic               div_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

  state_t               state_reg;
  logic [CW-1:0]        count_reg;
  logic [WIDTH-1:0]     rem_reg;
  logic [WIDTH-1:0]     quo_reg;
  logic [WIDTH-1:0]     divisor_reg;
  logic                 qneg_reg;
  logic                 rneg_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 div_ready_reg;

  logic                 opa_neg;
  logic                 opb_neg;
  logic [WIDTH-1:0]     opa_abs;
  logic [WIDTH-1:0]     opb_abs;
  logic                 start_ok;

  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       sub_b;
  logic [WIDTH+1:0]     borrow;
  logic [WIDTH-1:0]     diff;
  logic                 fits;
  logic [WIDTH-1:0]     rem_step;
  logic [WIDTH-1:0]     quo_step;
  logic [WIDTH-1:0]     rem_fixed;
  logic [WIDTH-1:0]     quo_fixed;
  logic                 last_step;

  // Operand conditioning: the core always divides magnitudes, signs are restored at the end.
  assign opa_neg  = div_signed & opA[WIDTH-1];
  assign opb_neg  = div_signed & opB[WIDTH-1];
  assign opa_abs  = opa_neg ? (~opA + 1'b1) : opA;
  assign opb_abs  = opb_neg ? (~opB + 1'b1) : opB;
  assign start_ok = div_start & ~flush;

  // Partial remainder gets the next dividend bit; it always fits in WIDTH+1 bits
  // because the previous remainder is strictly below the divisor.
  assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
  assign sub_b     = {1'b0, divisor_reg};
  assign borrow[0] = 1'b0;

  // Ripple-borrow subtractor; the final borrow-out doubles as the trial comparison.
  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
      assign borrow[gi+1] = (~rem_shift[gi] & sub_b[gi]) |
                            (~(rem_shift[gi] ^ sub_b[gi]) & borrow[gi]);
      if (gi < WIDTH) begin : g_diff
        assign diff[gi] = rem_shift[gi] ^ sub_b[gi] ^ borrow[gi];
      end
    end
  endgenerate

  assign fits      = ~borrow[WIDTH+1];
  assign rem_step  = fits ? diff : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo_reg[WIDTH-2:0], fits};
  assign rem_fixed = rneg_reg ? (~rem_step + 1'b1) : rem_step;
  assign quo_fixed = qneg_reg ? (~quo_step + 1'b1) : quo_step;
  assign last_step = (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      divisor_reg   <= '0;
      qneg_reg      <= 1'b0;
      rneg_reg      <= 1'b0;
      result_reg    <= '0;
      div_ready_reg <= 1'b0;
    end else begin
      div_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            count_reg <= '0;
            qneg_reg  <= opa_neg ^ opb_neg;
            rneg_reg  <= opa_neg;
            if (opB == '0) begin
              // Raw dividend is kept so it can be returned as HI.
              quo_reg   <= opA;
              state_reg <= ZERO;
            end else begin
              rem_reg     <= '0;
              quo_reg     <= opa_abs;
              divisor_reg <= opb_abs;
              state_reg   <= RUN;
            end
          end
        end
        ZERO: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            result_reg    <= {quo_reg, {WIDTH{1'b1}}};
            div_ready_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        RUN: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            rem_reg   <= rem_step;
            quo_reg   <= quo_step;
            count_reg <= count_reg + 1'b1;
            if (last_step) begin
              result_reg    <= {rem_fixed, quo_fixed};
              div_ready_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        DONE: begin
          // The held div_start belongs to the instruction now leaving EX.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall_div = ~rst & ~flush &
                     (((state_reg == IDLE) & div_start) |
                      (state_reg == ZERO) | (state_reg == RUN));
  assign div_ready = div_ready_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, results, flush, reset, back-to-back.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        stall_div;
  logic        div_ready;
  logic [63:0] result;

  int n_cmp = 0;
  int n_err = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .opA        (opA),
    .opB        (opB),
    .flush      (flush),
    .stall_div  (stall_div),
    .div_ready  (div_ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the operation.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int   lat;
    logic stall_gap;
    logic stall_done;
    lat        = -1;
    stall_gap  = 1'b0;
    stall_done = 1'b1;
    div_signed = sgn;
    opA        = a;
    opB        = b;
    div_start  = 1'b1;
    for (int c = 0; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (div_ready) begin
        lat        = c;
        stall_done = stall_div;
      end else if (!stall_div) begin
        stall_gap = 1'b1;
      end
      @(posedge clk);
      #1;
      if (c == 0) begin
        opA        = 32'hDEAD_BEEF;
        opB        = 32'h0;
        div_signed = ~sgn;
      end
    end
    div_start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stall busy"}, 64'(stall_gap), 64'd0);
    check({tag, " stall done"}, 64'(stall_done), 64'd0);
    check({tag, " result"}, result, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    div_start  = 1'b1;
    div_signed = 1'b0;
    opA        = 32'd100;
    opB        = 32'd7;
    flush      = 1'b0;
    #12;
    check("reset stall", 64'(stall_div), 64'd0);
    check("reset ready", 64'(div_ready), 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;
    @(posedge clk);
    #1;

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
    do_div("divu 9/3 b2b", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);
    do_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
    do_div("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
    do_div("divu big", 1'b0, 32'hFFFFFFFF, 32'h80000000, 33, 64'h7FFFFFFF_00000001);
    do_div("divu 3/10", 1'b0, 32'd3, 32'd10, 33, 64'h00000003_00000000);
    do_div("divu 5/0", 1'b0, 32'd5, 32'd0, 2, 64'h00000005_FFFFFFFF);
    do_div("div -5/0", 1'b1, 32'hFFFFFFFB, 32'd0, 2, 64'hFFFFFFFB_FFFFFFFF);
    do_div("div -100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, 64'hFFFFFFFE_0000000E);

    // Flush in cycle 10 of a running divide.
    div_signed = 1'b0;
    opA        = 32'd100;
    opB        = 32'd7;
    div_start  = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    #1;
    check("flush stall", 64'(stall_div), 64'd0);
    @(negedge clk);
    check("flush ready", 64'(div_ready), 64'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    check("post-flush stall", 64'(stall_div), 64'd0);
    check("post-flush ready", 64'(div_ready), 64'd0);
    @(posedge clk);
    #1;
    check("flush result held", result, 64'hFFFFFFFE_0000000E);
    do_div("divu 9/3 after flush", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);

    // Flush arriving in DONE must not suppress the ready pulse.
    div_signed = 1'b0;
    opA        = 32'd7;
    opB        = 32'd0;
    div_start  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush in done ready", 64'(div_ready), 64'd1);
    check("flush in done stall", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    check("ready single pulse", 64'(div_ready), 64'd0);
    check("flush in done result", result, 64'h00000007_FFFFFFFF);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk);
    #1;
    div_signed = 1'b0;
    opA        = 32'd100;
    opB        = 32'd7;
    div_start  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("mid-run rst stall", 64'(stall_div), 64'd0);
    check("mid-run rst ready", 64'(div_ready), 64'd0);
    check("mid-run rst result", result, 64'd0);
    #2;
    rst       = 1'b0;
    div_start = 1'b0;
    @(posedge clk);
    #1;
    do_div("divu 1000/10 after rst", 1'b0, 32'd1000, 32'd10, 33, 64'h00000000_00000064);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
